if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU; directly upstream of decode (register-file read).
- Holds the PC and drives the instruction-memory address. Latches the fetched word into the IF/ID pipeline register.
- Detects load-use hazards against the ID/EX stage and stalls fetch. Handles branch/jump redirects by flushing IF/ID.
- Keeps saturating fetch and stall counters for the performance bench.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0)
CNT_W, 16, width of fetch_cnt and stall_cnt

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
im_addr  output  32  instruction-memory address (= current PC)
im_instr  input  32  instruction word from combinational instruction memory
redirect_en  input  1  branch taken / jump resolved downstream; load redirect_target this cycle
redirect_target  input  32  new PC; bits [1:0] ignored (forced 0)
id_ex_mem_r  input  1  instruction in ID/EX is a load
id_ex_rt  input  5  destination (rt) of that load
if_id_instr  output  32  IF/ID instruction register
if_id_pc4  output  32  IF/ID PC+4 register
if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble)
hazard_stall  output  1  combinational load-use stall; decode uses it to zero ID/EX control
fetch_cnt  output  CNT_W  number of instructions latched valid into IF/ID, saturating
stall_cnt  output  CNT_W  number of stall cycles, saturating

Behaviour:
- One clock domain. All state updates on the rising clk edge. Reset is synchronous active-low and has top priority.
- Reset (rst_n=0 at edge):
  - pc=RESET_PC
  - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0
  - fetch_cnt=0, stall_cnt=0
- im_addr = pc, combinationally. Instruction memory has zero-cycle read, so im_instr belongs to pc in the same cycle.
- Hazard detection (combinational, from IF/ID fields rs=if_id_instr[25:21], rt=if_id_instr[20:16]):
  - hazard_stall = if_id_valid & id_ex_mem_r & (id_ex_rt!=0) & ((id_ex_rt==rs) | (id_ex_rt==rt)).
  - hazard_stall is gated to 0 when redirect_en=1.
- Per-cycle update priority, rst_n=1:
  1. redirect_en=1:
     - pc={redirect_target[31:2],2'b00}
     - if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0 (flush)
     - Redirect wins over a simultaneous hazard; the stall is discarded.
  2. else hazard_stall=1:
     - pc held; IF/ID held unchanged.
     - stall_cnt increments (saturating).
  3. else (normal):
     - pc=pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
     - if_id_instr=im_instr, if_id_pc4=pc+4, if_id_valid=1.
     - fetch_cnt increments (saturating).
- Counters saturate at all-ones; no wrap.
- Latency: an instruction at PC p appears in IF/ID one cycle after pc==p with no stall.
- Redirect penalty: exactly one bubble (the flushed slot). The target word is in IF/ID on the 2nd edge after redirect.
- Reset asserted mid-stall or mid-redirect: reset values apply at that edge. The next cycle fetches RESET_PC.
- No X propagation: outputs are defined from the first reset edge onward.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: rst_n=0 for 2 cycles, release; IM returns word = address.
  - Required: im_addr 0,4,8,C on successive cycles.
  - Required: IF/ID shows instr 0,4,8 with pc4 4,8,C and valid=1.
  - Required: fetch_cnt=3 after 3 edges.
- Load-use stall:
  - Stimulus: IF/ID holds 0x012A4020 (add $8,$9,$10); id_ex_mem_r=1, id_ex_rt=10.
  - Required: hazard_stall=1, pc and IF/ID frozen for 1 cycle, stall_cnt=1.
  - Repeat with id_ex_rt=0: required hazard_stall=0, no stall.
- Redirect:
  - Stimulus: at pc=0x10, redirect_en=1, target=0x43.
  - Required: next pc=0x40, if_id_valid=0, if_id_instr=0.
  - Required: the following edge latches the word at 0x40 with pc4=0x44.
- Redirect during hazard:
  - Stimulus: hazard conditions true and redirect_en=1 in the same cycle.
  - Required: hazard_stall=0, pc=target, IF/ID flushed, stall_cnt unchanged.
- Wrap and saturation:
  - Stimulus: redirect to 0xFFFF_FFFC, then run.
  - Required: pc goes 0xFFFF_FFFC → 0x0, with pc4=0 latched.
  - Stimulus: CNT_W=4 build, run 20 fetches.
  - Required: fetch_cnt holds 4'hF.
- Reset mid-stall:
  - Stimulus: rst_n=0 while hazard_stall=1.
  - Required: next cycle pc=RESET_PC, valid=0, both counters 0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and a zero-latency instruction memory.
// The fetch stage drives the address; memory returns the word in the same cycle.
interface if_fetch_stage_if;
  logic [31:0] im_addr;
  logic [31:0] im_instr;

  modport master (output im_addr, input im_instr);
  modport slave  (input im_addr, output im_instr);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, load-use stall
// detection, redirect flush and saturating fetch/stall performance counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  if_fetch_stage_if.master imem,
  input  logic             redirect_en,
  input  logic [31:0]      redirect_target,
  input  logic             id_ex_mem_r,
  input  logic [4:0]       id_ex_rt,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      if_id_instr_q, if_id_instr_d;
  logic [31:0]      if_id_pc4_q, if_id_pc4_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        load_use;
  logic [31:0] pc_plus4;

  assign if_id_rs = if_id_instr_q[25:21];
  assign if_id_rt = if_id_instr_q[20:16];
  assign pc_plus4 = pc_q + 32'd4;

  // A pending redirect squashes the instruction in IF/ID, so its hazard is moot.
  assign load_use = if_id_valid_q & id_ex_mem_r & (id_ex_rt != 5'd0) &
                    ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
  assign hazard_stall = load_use & ~redirect_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    fetch_cnt_d   = fetch_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (redirect_en) begin
      pc_d          = {redirect_target[31:2], 2'b00};
      if_id_instr_d = NOP_WORD;
      if_id_pc4_d   = 32'd0;
      if_id_valid_d = 1'b0;
    end else if (hazard_stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      pc_d          = pc_plus4;
      if_id_instr_d = imem.im_instr;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      fetch_cnt_d   = sat_inc(fetch_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_WORD;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      fetch_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_cnt_q   <= fetch_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign imem.im_addr = pc_q;
  assign if_id_instr  = if_id_instr_q;
  assign if_id_pc4    = if_id_pc4_q;
  assign if_id_valid  = if_id_valid_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, load-use stall, redirect,
// redirect-over-hazard, PC wrap, counter saturation (CNT_W=4 copy) and reset mid-stall.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic        id_ex_mem_r;
  logic [4:0]  id_ex_rt;
  logic        use_force;
  logic [31:0] force_word;

  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid, hazard_stall;
  logic [15:0] fetch_cnt, stall_cnt;

  logic [31:0] s_instr, s_pc4;
  logic        s_valid, s_hazard;
  logic [3:0]  s_fetch, s_stall;

  int tests_run;
  int tests_failed;

  if_fetch_stage_if imem_bus ();
  if_fetch_stage_if imem_small ();

  // Memory returns the address as the word unless a specific word is injected.
  assign imem_bus.im_instr   = use_force ? force_word : imem_bus.im_addr;
  assign imem_small.im_instr = imem_small.im_addr;

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .imem(imem_bus),
    .redirect_en(redirect_en), .redirect_target(redirect_target),
    .id_ex_mem_r(id_ex_mem_r), .id_ex_rt(id_ex_rt),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .hazard_stall(hazard_stall), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .imem(imem_small),
    .redirect_en(1'b0), .redirect_target(32'h0),
    .id_ex_mem_r(1'b0), .id_ex_rt(5'd0),
    .if_id_instr(s_instr), .if_id_pc4(s_pc4), .if_id_valid(s_valid),
    .hazard_stall(s_hazard), .fetch_cnt(s_fetch), .stall_cnt(s_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check_eq({tag, "_instr"}, if_id_instr, instr);
    check_eq({tag, "_pc4"}, if_id_pc4, pc4);
    check_eq({tag, "_valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    redirect_en     = 1'b0;
    redirect_target = 32'h0;
    id_ex_mem_r     = 1'b0;
    id_ex_rt        = 5'd0;
    use_force       = 1'b0;
    force_word      = 32'h0;

    // Reset and sequential fetch
    tick();
    tick();
    check_eq("rst_addr", imem_bus.im_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_eq("rst_fetch", {16'd0, fetch_cnt}, 32'd0);
    check_eq("rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("seq_addr0", imem_bus.im_addr, 32'h0);
    tick();
    check_eq("seq_addr1", imem_bus.im_addr, 32'h4);
    check_ifid("seq1", 32'h0, 32'h4, 1'b1);
    tick();
    check_eq("seq_addr2", imem_bus.im_addr, 32'h8);
    check_ifid("seq2", 32'h4, 32'h8, 1'b1);
    tick();
    check_eq("seq_addr3", imem_bus.im_addr, 32'hC);
    check_ifid("seq3", 32'h8, 32'hC, 1'b1);
    check_eq("seq_fetch3", {16'd0, fetch_cnt}, 32'd3);

    // Run to 20 fetches; the 4-bit copy must saturate at 0xF
    for (int i = 0; i < 17; i++) tick();
    check_eq("run_fetch20", {16'd0, fetch_cnt}, 32'd20);
    check_eq("run_addr", imem_bus.im_addr, 32'h50);
    check_eq("sat_fetch4", {28'd0, s_fetch}, 32'hF);

    // Load-use stall on rt match: add $8,$9,$10 behind a load to $10
    use_force  = 1'b1;
    force_word = 32'h012A_4020;
    tick();
    use_force = 1'b0;
    check_ifid("lu_load", 32'h012A_4020, 32'h54, 1'b1);
    id_ex_mem_r = 1'b1;
    id_ex_rt    = 5'd10;
    #1;
    check_eq("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    check_eq("lu_addr_hold", imem_bus.im_addr, 32'h54);
    check_ifid("lu_hold", 32'h012A_4020, 32'h54, 1'b1);
    check_eq("lu_stall1", {16'd0, stall_cnt}, 32'd1);
    check_eq("lu_fetch", {16'd0, fetch_cnt}, 32'd21);
    id_ex_rt = 5'd0;
    #1;
    check_eq("lu_rt0_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    check_eq("lu_rt0_addr", imem_bus.im_addr, 32'h58);
    check_ifid("lu_rt0", 32'h54, 32'h58, 1'b1);
    check_eq("lu_rt0_stall", {16'd0, stall_cnt}, 32'd1);
    id_ex_mem_r = 1'b0;

    // Redirect: first reach pc=0x10, then redirect to 0x43 -> 0x40
    redirect_en     = 1'b1;
    redirect_target = 32'h10;
    tick();
    check_eq("rd_pc10", imem_bus.im_addr, 32'h10);
    redirect_target = 32'h43;
    tick();
    redirect_en = 1'b0;
    check_eq("rd_pc40", imem_bus.im_addr, 32'h40);
    check_ifid("rd_flush", 32'h0, 32'h0, 1'b0);
    tick();
    check_ifid("rd_target", 32'h40, 32'h44, 1'b1);
    check_eq("rd_addr44", imem_bus.im_addr, 32'h44);

    // Redirect with simultaneous hazard (rs match on $9)
    use_force  = 1'b1;
    force_word = 32'h012A_4020;
    tick();
    use_force   = 1'b0;
    id_ex_mem_r = 1'b1;
    id_ex_rt    = 5'd9;
    #1;
    check_eq("rh_hazard_rs", {31'd0, hazard_stall}, 32'd1);
    redirect_en     = 1'b1;
    redirect_target = 32'h100;
    #1;
    check_eq("rh_hazard_gated", {31'd0, hazard_stall}, 32'd0);
    tick();
    check_eq("rh_pc", imem_bus.im_addr, 32'h100);
    check_ifid("rh_flush", 32'h0, 32'h0, 1'b0);
    check_eq("rh_stall", {16'd0, stall_cnt}, 32'd1);
    id_ex_mem_r = 1'b0;
    id_ex_rt    = 5'd0;

    // PC wrap at the top of the address space
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_en = 1'b0;
    check_eq("wr_pc", imem_bus.im_addr, 32'hFFFF_FFFC);
    tick();
    check_eq("wr_addr0", imem_bus.im_addr, 32'h0);
    check_ifid("wr", 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Reset asserted while stalled
    use_force  = 1'b1;
    force_word = 32'h012A_4020;
    tick();
    use_force   = 1'b0;
    id_ex_mem_r = 1'b1;
    id_ex_rt    = 5'd10;
    #1;
    check_eq("rs_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    check_eq("rs_stall2", {16'd0, stall_cnt}, 32'd2);
    rst_n = 1'b0;
    tick();
    check_eq("rs_pc", imem_bus.im_addr, 32'h0);
    check_ifid("rs", 32'h0, 32'h0, 1'b0);
    check_eq("rs_fetch0", {16'd0, fetch_cnt}, 32'd0);
    check_eq("rs_stall0", {16'd0, stall_cnt}, 32'd0);
    rst_n       = 1'b1;
    id_ex_mem_r = 1'b0;
    id_ex_rt    = 5'd0;
    tick();
    check_ifid("rs_refetch", 32'h0, 32'h4, 1'b1);
    check_eq("rs_fetch1", {16'd0, fetch_cnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
